multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_WAIT, default 0, meaning extra wait cycles per memory access (legal range 0..15).
REQ-002 clk  input  1  the block's single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 op  input  6  opcode, instruction[31:26], from the instruction register.
REQ-005 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath enables and selects.
REQ-006 PCSource, ALUOp, ALUSrcB  output  2 each  datapath selects.
REQ-007 state  output  4  current state encoding, for debug.
REQ-008 illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode.

Function
REQ-009 The block SHALL be a Moore FSM; outputs decode from the state register and wait counter only.
REQ-010 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9.
REQ-011 Outputs not listed for a state SHALL be 0.
REQ-012 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
REQ-013 FETCH SHALL drive IRWrite=1 and PCWrite=1 only in its final cycle.
REQ-014 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-015 DECODE SHALL branch on op: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP (see REQ-027); any other op -> FETCH with illegal_op=1.
REQ-016 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD if op=100011, else MEMWR.
REQ-017 MEMRD SHALL drive MemRead=1, IorD=1, then go to MEMWB.
REQ-018 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-019 MEMWR SHALL drive MemWrite=1, IorD=1 in every cycle, then go to FETCH.
REQ-020 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RWB.
REQ-021 RWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-022 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-023 JUMP SHALL drive PCWrite=1, PCSource=10, then go to FETCH.
REQ-024 Memory states (FETCH, MEMRD, MEMWR) SHALL last MEM_WAIT+1 cycles, counted by a 4-bit wait counter.
REQ-025 The wait counter SHALL clear on entry to each memory state, increment each cycle in it, and allow exit when it equals MEM_WAIT.
REQ-026 Instruction cycle counts with MEM_WAIT=W SHALL be: lw 5+2W, sw 4+2W, R-type 4+W, beq 3+W, j 3+W.

Configuration
REQ-027 With JUMP_SUPPORT_EN defined, op 000010 SHALL go to JUMP.
REQ-028 Without JUMP_SUPPORT_EN, the JUMP state SHALL be absent, and op 000010 SHALL be illegal (FETCH, illegal_op pulse).

Reset
REQ-029 While rst=1 at a clock edge, state SHALL become FETCH and the wait counter 0.
REQ-030 While rst=1, the outputs PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite and illegal_op SHALL be forced to 0; state SHALL read 0.
REQ-031 Reset asserted in any state, including mid-wait, SHALL abandon the instruction, with no write enable asserted in that cycle.

Structure
REQ-032 Shared package mc_ctrl_pkg SHALL hold the state encodings, the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J) and the ALUOp/PCSource/ALUSrcB code constants.
REQ-033 The wait counter SHALL be one sub-module, mem_wait_counter (inputs clear and enable; output done when count==MEM_WAIT).

Verification
REQ-034 Directed scenario, MEM_WAIT=0, op=100011 after reset: states SHALL be 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-035 Directed scenario, MEM_WAIT=2, op=101011: FETCH SHALL hold 3 cycles with IRWrite and PCWrite high only in the 3rd cycle; MEMWR SHALL hold 3 cycles with MemWrite=1 throughout; total SHALL be 8 cycles.
REQ-036 Directed scenario, op=000000: states SHALL be 0,1,6,7,0; ALUOp SHALL be 10 in EXEC; RegDst=1 in RWB.
REQ-037 Directed scenario, op=000100: BRANCH SHALL show PCWriteCond=1, PCSource=01, ALUOp=01, then FETCH.
REQ-038 Directed scenario, op=000010 and op=111111: with JUMP_SUPPORT_EN, op=000010 SHALL reach state 9 with PCSource=10; without it, op=000010 SHALL pulse illegal_op and return to FETCH; op=111111 SHALL always pulse illegal_op.
REQ-039 Directed scenario, rst=1 asserted during MEMRD wait (MEM_WAIT=3, count=1): the next state SHALL be 0, the counter 0, and MemRead=0 while rst=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module : mc_ctrl_pkg
// Brief  : Shared encodings for the multicycle controller. The JUMP state
//          exists only when JUMP_SUPPORT_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
`ifdef JUMP_SUPPORT_EN
      BRANCH = 4'd8,
      JUMP   = 4'd9
`else
      BRANCH = 4'd8
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BOFF = 2'b11;

   function automatic logic is_mem_state(input state_t s);
      return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
   endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_if.sv
// ============================================================================
// Module : multicycle_control_if
// Brief  : Opcode in, datapath enables/selects out of the multicycle controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface multicycle_control_if;
   logic [5:0] op;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       MemtoReg;
   logic       IRWrite;
   logic       ALUSrcA;
   logic       RegWrite;
   logic       RegDst;
   logic [1:0] PCSource;
   logic [1:0] ALUOp;
   logic [1:0] ALUSrcB;
   logic [3:0] state;
   logic       illegal_op;

   modport master (
      input  op,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
             IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
             state, illegal_op
   );

   modport slave (
      output op,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
             IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
             state, illegal_op
   );
endinterface

`default_nettype wire

// File: rtl/mem_wait_counter.sv
// ============================================================================
// Module : mem_wait_counter
// Brief  : 4-bit cycle counter for memory states; done when count hits MEM_WAIT.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_wait_counter #(
   parameter int MEM_WAIT = 0
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic clear,
   input  wire logic enable,
   output logic      done
);

   logic [3:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_count <= 4'd0;
      end else if (enable) begin
         r_count <= r_count + 4'd1;
      end
   end

   assign done = (r_count == 4'(MEM_WAIT));

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module : multicycle_control
// Brief  : Moore FSM controller for a multicycle MIPS datapath.
//          Define JUMP_SUPPORT_EN to add the JUMP state for op 000010.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module multicycle_control
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 0
) (
   input  wire logic              clk,
   input  wire logic              rst,
   multicycle_control_if.master   bus
);

   state_t     r_state;
   state_t     w_next;
   logic       w_wait_done;
   logic       w_illegal;
   logic       w_pc_write, w_pc_write_cond, w_iord, w_mem_read, w_mem_write;
   logic       w_memto_reg, w_ir_write, w_alu_src_a, w_reg_write, w_reg_dst;
   logic [1:0] w_pc_source, w_alu_op, w_alu_src_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Any state change clears the counter, so each memory state starts at 0.
   mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
      .clk    (clk),
      .rst    (rst),
      .clear  (w_next != r_state),
      .enable (is_mem_state(r_state)),
      .done   (w_wait_done)
   );

   always_comb begin
      w_next    = r_state;
      w_illegal = 1'b0;
      case (r_state)
         FETCH:  if (w_wait_done) w_next = DECODE;
         DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: w_next = MEMADR;
               OP_RTYPE:     w_next = EXEC;
               OP_BEQ:       w_next = BRANCH;
`ifdef JUMP_SUPPORT_EN
               OP_J:         w_next = JUMP;
`endif
               default: begin
                  w_next    = FETCH;
                  w_illegal = 1'b1;
               end
            endcase
         end
         MEMADR: w_next = (bus.op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  if (w_wait_done) w_next = MEMWB;
         MEMWB:  w_next = FETCH;
         MEMWR:  if (w_wait_done) w_next = FETCH;
         EXEC:   w_next = RWB;
         RWB:    w_next = FETCH;
         BRANCH: w_next = FETCH;
`ifdef JUMP_SUPPORT_EN
         JUMP:   w_next = FETCH;
`endif
         default: w_next = FETCH;
      endcase
   end

   always_comb begin
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_iord          = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_memto_reg     = 1'b0;
      w_ir_write      = 1'b0;
      w_alu_src_a     = 1'b0;
      w_reg_write     = 1'b0;
      w_reg_dst       = 1'b0;
      w_pc_source     = PCSRC_ALU;
      w_alu_op        = ALUOP_ADD;
      w_alu_src_b     = SRCB_REG;
      case (r_state)
         FETCH: begin
            w_mem_read  = 1'b1;
            w_alu_src_b = SRCB_FOUR;
            w_ir_write  = w_wait_done;
            w_pc_write  = w_wait_done;
         end
         DECODE: w_alu_src_b = SRCB_BOFF;
         MEMADR: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = SRCB_IMM;
         end
         MEMRD: begin
            w_mem_read = 1'b1;
            w_iord     = 1'b1;
         end
         MEMWB: begin
            w_reg_write = 1'b1;
            w_memto_reg = 1'b1;
         end
         MEMWR: begin
            w_mem_write = 1'b1;
            w_iord      = 1'b1;
         end
         EXEC: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = ALUOP_FUNCT;
         end
         RWB: begin
            w_reg_write = 1'b1;
            w_reg_dst   = 1'b1;
         end
         BRANCH: begin
            w_alu_src_a     = 1'b1;
            w_alu_op        = ALUOP_SUB;
            w_pc_write_cond = 1'b1;
            w_pc_source     = PCSRC_ALUOUT;
         end
`ifdef JUMP_SUPPORT_EN
         JUMP: begin
            w_pc_write  = 1'b1;
            w_pc_source = PCSRC_JUMP;
         end
`endif
         default: ;
      endcase
   end

   // Reset gates every write/strobe so an abandoned instruction writes nothing.
   assign bus.PCWrite     = w_pc_write      & ~rst;
   assign bus.PCWriteCond = w_pc_write_cond & ~rst;
   assign bus.IRWrite     = w_ir_write      & ~rst;
   assign bus.MemRead     = w_mem_read      & ~rst;
   assign bus.MemWrite    = w_mem_write     & ~rst;
   assign bus.RegWrite    = w_reg_write     & ~rst;
   assign bus.illegal_op  = w_illegal       & ~rst;
   assign bus.IorD        = w_iord;
   assign bus.MemtoReg    = w_memto_reg;
   assign bus.ALUSrcA     = w_alu_src_a;
   assign bus.RegDst      = w_reg_dst;
   assign bus.PCSource    = w_pc_source;
   assign bus.ALUOp       = w_alu_op;
   assign bus.ALUSrcB     = w_alu_src_b;
   assign bus.state       = rst ? 4'd0 : r_state;

endmodule

`default_nettype wire
